// File: rtl/vram_pkg.sv
// Shared constants and state encoding for the video RAM arbiter.
// Op codes match the CPU side encoding of cpu_op.
package vram_pkg;

    localparam int unsigned HBITS_DEF  = 7;
    localparam int unsigned VBITS_DEF  = 6;
    localparam int unsigned PIX_W      = 2;
    localparam int unsigned VRAM_WORDS = 8192;

    localparam logic [1:0] OP_READ  = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_XOR   = 2'd2;
    localparam logic [1:0] OP_CLEAR = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StIssueRd,
        StWaitRd,
        StIssueWr,
        StClear
    } state_e;

endpackage

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: scan-out reads always win the slot, CPU operations
// (READ/WRITE/XOR/CLEAR) use the free slots through a valid/ready handshake.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int unsigned HBITS = HBITS_DEF,
    parameter int unsigned VBITS = VBITS_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   vid_req,
    input  logic [HBITS-1:0]       vid_hpos,
    input  logic [VBITS-1:0]       vid_vpos,
    output logic                   vid_rvalid,
    output logic [1:0]             vid_pixel,
    input  logic                   cpu_valid,
    output logic                   cpu_ready,
    input  logic [1:0]             cpu_op,
    input  logic [HBITS-1:0]       cpu_hpos,
    input  logic [VBITS-1:0]       cpu_vpos,
    input  logic [1:0]             cpu_pixeli,
    output logic                   cpu_done,
    output logic [1:0]             cpu_pixelo,
    output logic                   cpu_collide,
    output logic [HBITS+VBITS-1:0] mem_addr,
    output logic                   mem_we,
    output logic [1:0]             mem_din,
    input  logic [1:0]             mem_dout
);

    localparam int unsigned AW = HBITS + VBITS;

    state_e          state_q, state_d;
    logic [1:0]      op_q, op_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [1:0]      data_q, data_d;
    logic [1:0]      old_q, old_d;
    logic            collide_q, collide_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   last_addr_q, last_addr_d;
    logic            vid_rvalid_q, vid_rvalid_d;
    logic [1:0]      vid_pix_q, vid_pix_d;
    logic            free_slot;

    assign free_slot = ~vid_req;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            op_q         <= OP_READ;
            addr_q       <= '0;
            data_q       <= '0;
            old_q        <= '0;
            collide_q    <= 1'b0;
            cnt_q        <= '0;
            last_addr_q  <= '0;
            vid_rvalid_q <= 1'b0;
            vid_pix_q    <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            old_q        <= old_d;
            collide_q    <= collide_d;
            cnt_q        <= cnt_d;
            last_addr_q  <= last_addr_d;
            vid_rvalid_q <= vid_rvalid_d;
            vid_pix_q    <= vid_pix_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        addr_d    = addr_q;
        data_d    = data_q;
        old_d     = old_q;
        collide_d = collide_q;
        cnt_d     = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (cpu_valid) begin
                    op_d      = cpu_op;
                    addr_d    = {cpu_vpos, cpu_hpos};
                    data_d    = cpu_pixeli;
                    old_d     = '0;
                    collide_d = 1'b0;
                    cnt_d     = '0;
                    unique case (cpu_op)
                        OP_READ, OP_XOR: state_d = StIssueRd;
                        OP_WRITE:        state_d = StIssueWr;
                        default:         state_d = StClear;
                    endcase
                end
            end
            StIssueRd: begin
                if (free_slot) state_d = StWaitRd;
            end
            StWaitRd: begin
                old_d = mem_dout;
                if (op_q == OP_XOR) begin
                    // data_q now carries the XORed pixel for the write-back.
                    data_d    = mem_dout ^ data_q;
                    collide_d = mem_dout[0] & data_q[0];
                    state_d   = StIssueWr;
                end else begin
                    state_d = StIdle;
                end
            end
            StIssueWr: begin
                if (free_slot) state_d = StIdle;
            end
            StClear: begin
                if (free_slot) begin
                    if (cnt_q == '1) begin
                        cnt_d   = '0;
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        mem_we      = 1'b0;
        mem_din     = '0;
        mem_addr    = last_addr_q;
        cpu_done    = 1'b0;
        cpu_ready   = (state_q == StIdle);
        cpu_pixelo  = old_q;
        cpu_collide = 1'b0;
        if (vid_req) begin
            mem_addr = {vid_vpos, vid_hpos};
        end else begin
            unique case (state_q)
                StIssueRd: mem_addr = addr_q;
                StIssueWr: begin
                    mem_addr    = addr_q;
                    mem_we      = 1'b1;
                    mem_din     = data_q;
                    cpu_done    = 1'b1;
                    cpu_collide = collide_q;
                end
                StClear: begin
                    mem_addr = cnt_q;
                    mem_we   = 1'b1;
                    cpu_done = (cnt_q == '1);
                end
                default: ;
            endcase
        end
        if (state_q == StWaitRd && op_q == OP_READ) begin
            cpu_done   = 1'b1;
            cpu_pixelo = mem_dout;
        end
        vid_rvalid   = vid_rvalid_q;
        vid_pixel    = vid_rvalid_q ? mem_dout : vid_pix_q;
        vid_pix_d    = vid_pixel;
        vid_rvalid_d = vid_req;
        last_addr_d  = mem_addr;
    end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Owns the single-port 128×64×2-bit video RAM and shares it between two requesters: video scan-out, which only reads and has absolute priority, and the CPU, which issues READ, WRITE, XOR (sprite draw with collision) and CLEAR operations. CPU operations use a valid/ready handshake and use only the memory cycles that scan-out leaves free. The block sits between `cpu` / the display timing generator and the VRAM macro. The CPU no longer drives VRAM directly.

## Interface
Parameters:
- `HBITS`, default 7: horizontal address width (128 columns).
- `VBITS`, default 6: vertical address width (64 rows).

Ports, clock and reset first:
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `vid_req`  in  1  scan-out read request this cycle.
- `vid_hpos`  in  HBITS  scan-out column.
- `vid_vpos`  in  VBITS  scan-out row.
- `vid_rvalid`  out  1  scan-out read data valid.
- `vid_pixel`  out  2  scan-out read data.
- `cpu_valid`  in  1  CPU operation request.
- `cpu_ready`  out  1  arbiter can accept an operation.
- `cpu_op`  in  2  0 READ, 1 WRITE, 2 XOR, 3 CLEAR.
- `cpu_hpos`  in  HBITS  CPU column (ignored for CLEAR).
- `cpu_vpos`  in  VBITS  CPU row (ignored for CLEAR).
- `cpu_pixeli`  in  2  write / XOR data.
- `cpu_done`  out  1  one-cycle completion pulse.
- `cpu_pixelo`  out  2  READ result, or old pixel for XOR; valid with `cpu_done`.
- `cpu_collide`  out  1  XOR turned a lit pixel off; valid with `cpu_done`.
- `mem_addr`  out  HBITS+VBITS  VRAM address, {vpos, hpos}.
- `mem_we`  out  1  VRAM write enable.
- `mem_din`  out  2  VRAM write data.
- `mem_dout`  in  2  VRAM read data, 1-cycle latency.

## Operation
Slot rule:
- One VRAM access per cycle.
- A slot is free when `vid_req`=0.
- When `vid_req`=1, the slot always goes to video: `mem_addr`={vid_vpos,vid_hpos}, `mem_we`=0.
- A CPU access happens only in a free slot.
- In an idle free slot: `mem_we`=0 and `mem_addr` holds its last value.

Handshake:
- `cpu_ready`=1 only in IDLE.
- An operation is accepted when `cpu_valid`&&`cpu_ready`.
- On acceptance, op, address and data are latched. Later changes on the inputs have no effect.

FSM states: IDLE, ISSUE_RD, WAIT_RD, ISSUE_WR, CLEAR.
- IDLE, on accept: READ/XOR → ISSUE_RD; WRITE → ISSUE_WR; CLEAR → CLEAR with counter=0.
- ISSUE_RD: in a free slot, drive the read and go to WAIT_RD; otherwise stay.
- WAIT_RD: capture `mem_dout` as old.
  - READ: `cpu_done`=1, `cpu_pixelo`=old, go to IDLE.
  - XOR: new=old^pixeli, collide=old[0]&pixeli[0], go to ISSUE_WR.
- ISSUE_WR: in a free slot, drive the write (data = latched data, or new for XOR), pulse `cpu_done`, go to IDLE. `cpu_pixelo`/`cpu_collide` are presented with the pulse.
- CLEAR:
  - In each free slot, write 0 to address=counter and increment the counter.
  - The write to address 8191 pulses `cpu_done` and returns to IDLE.
  - The counter is 13 bits and is not allowed to wrap.
- Video never writes. XOR read and write need no locking, because only the CPU modifies VRAM.
- `cpu_collide`=0 for READ, WRITE and CLEAR.

Reset:
- Effect, in the cycle after `reset`: state=IDLE, counter=0, any in-flight op dropped.
- Outputs after reset: `cpu_ready`=1, `cpu_done`=0, `cpu_collide`=0, `cpu_pixelo`=0, `vid_rvalid`=0, `vid_pixel`=0, `mem_we`=0, `mem_addr`=0, `mem_din`=0.
- Reset mid-CLEAR leaves VRAM partially cleared. This is acceptable.

## Timing
- Video latency:
  - `vid_req` at cycle t → `vid_rvalid`=1 with `vid_pixel`=`mem_dout` at t+1.
  - Fixed latency, never stalled.
  - `vid_pixel` holds its value when `vid_rvalid`=0.
- CPU minimum latency, accept at t with no video traffic:
  - WRITE: done at t+1.
  - READ: done at t+2.
  - XOR: done at t+3.
  - CLEAR: done at t+8192.
  - Each cycle with `vid_req`=1 during an issue state adds one cycle.
- `mem_we`/`mem_din` are combinational from state and `vid_req`. `cpu_done` is registered only where noted by state.
- Back-to-back: `cpu_ready` returns in the cycle after `cpu_done`.
- Simultaneous `cpu_valid` and `vid_req` in IDLE: the CPU op is accepted, and video still gets the slot.

## Structure
- Package `vram_pkg`:
  - op-code constants `OP_READ`, `OP_WRITE`, `OP_XOR`, `OP_CLEAR`;
  - state encoding;
  - `HBITS`/`VBITS` defaults;
  - pixel width 2;
  - the `VRAM_WORDS`=8192 constant.
- Single module, no sub-modules. The `cpu` module becomes a requester and must wait on `cpu_done` instead of assuming single-cycle VRAM access.

## Test plan
- Reset, then idle: all outputs at their reset values and `cpu_ready`=1. Assert reset during XOR ISSUE_WR → no `mem_we` in the following cycle, state IDLE.
- Video stream with `vid_req`=1 for 128 cycles over row 5 preloaded with a pattern → `vid_pixel` matches each address exactly 1 cycle later, and the CPU issues nothing.
- WRITE (3,10,2'b11), then READ (3,10) with no video → first `cpu_done` 1 cycle after accept; READ `cpu_done` 2 cycles after accept with `cpu_pixelo`=3.
- XOR pixeli=3 onto a pixel of 3 → `cpu_collide`=1 and the pixel becomes 0. XOR again → `cpu_collide`=0 and the pixel is 3.
- WRITE accepted while `vid_req` is held high for 10 cycles → no `mem_we` during those 10 cycles, then the write issues in the first free cycle with `cpu_done`.
- CLEAR from a fully-set VRAM with a 50% `vid_req` duty → exactly 8192 writes of 0, a single `cpu_done`, and every address then reads 0.
